// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a start/ready handshake.
// ADD, SUB, NAND, PASSB and XOR take one cycle. A rotate by n > 0 takes one
// extra cycle per bit position. MUL runs W shift-add steps.
// The result and the parity, not-equal, zero and carry flags are registered
// and held until the next operation completes.
module alu_mc #(
    parameter int W    = 8,
    parameter int SH_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         flush,
    input  logic [2:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] rslt,
    output logic         pari,
    output logic         ne,
    output logic         zero,
    output logic         cout
);

    localparam int CNT_W = $clog2(W) + 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ROTR  = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_PASSB = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_ROTL  = 3'b110;
    localparam logic [2:0] OP_XOR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         cmd;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       work;    // value being rotated, or the shifting multiplicand
    logic [W-1:0]       acc;     // multiply accumulator
    logic [W-1:0]       mplr;    // multiplier, consumed LSB first
    logic               ne_run;  // not-equal flag captured at accept for iterative ops

    logic [SH_W-1:0]    sh;
    logic [W:0]         quick;
    logic               is_rot;
    logic [W-1:0]       rot_next;
    logic [W-1:0]       mul_next;
    logic [W-1:0]       step_res;

    // Single-cycle operations; bit W carries cout (ADD carry, SUB no-borrow).
    function automatic logic [W:0] quick_op(input logic [2:0] c,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W:0] r;
        r = '0;
        case (c)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                r    = {1'b0, a} - {1'b0, b};
                r[W] = ~r[W];
            end
            OP_NAND: r = {1'b0, ~(a & b)};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = {1'b0, b};   // PASSB, and rotates by zero
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rotr1(input logic [W-1:0] x);
        return {x[0], x[W-1:1]};
    endfunction

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    // ready is a pure decode of the state register.
    assign ready = (state != S_RUN);

    // Next-value logic for the single-cycle path and for one iteration step.
    always_comb begin
        sh       = inA[SH_W-1:0];
        quick    = quick_op(alu_cmd, inA, inB);
        is_rot   = (alu_cmd == OP_ROTR) || (alu_cmd == OP_ROTL);
        rot_next = (cmd == OP_ROTR) ? rotr1(work) : rotl1(work);
        mul_next = acc + (mplr[0] ? work : '0);
        step_res = (cmd == OP_MUL) ? mul_next : rot_next;
    end

    // Control FSM with the iteration datapath and the registered result and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cmd    <= '0;
            cnt    <= '0;
            work   <= '0;
            acc    <= '0;
            mplr   <= '0;
            ne_run <= 1'b0;
            done   <= 1'b0;
            rslt   <= '0;
            pari   <= 1'b0;
            ne     <= 1'b0;
            zero   <= 1'b0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        cmd    <= alu_cmd;
                        ne_run <= (inA != inB);
                        if (alu_cmd == OP_MUL) begin
                            acc   <= '0;
                            work  <= inA;
                            mplr  <= inB;
                            cnt   <= CNT_W'(W);
                            state <= S_RUN;
                        end else if (is_rot && (sh != '0)) begin
                            work  <= inB;
                            cnt   <= CNT_W'(sh);
                            state <= S_RUN;
                        end else begin
                            rslt  <= quick[W-1:0];
                            cout  <= quick[W];
                            pari  <= ^quick[W-1:0];
                            zero  <= (quick[W-1:0] == '0);
                            ne    <= (inA != inB);
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    done <= 1'b0;
                    if (flush) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        work <= (cmd == OP_MUL) ? (work << 1) : rot_next;
                        acc  <= mul_next;
                        mplr <= mplr >> 1;
                        cnt  <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            rslt  <= step_res;
                            cout  <= 1'b0;
                            pari  <= ^step_res;
                            zero  <= (step_res == '0);
                            ne    <= ne_run;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc against an arithmetic model.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         flush;
    logic [2:0]   alu_cmd;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         ready;
    logic         done;
    logic [W-1:0] rslt;
    logic         pari;
    logic         ne;
    logic         zero;
    logic         cout;

    int total = 0;
    int bad   = 0;

    alu_mc #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flush   (flush),
        .alu_cmd (alu_cmd),
        .inA     (inA),
        .inB     (inB),
        .ready   (ready),
        .done    (done),
        .rslt    (rslt),
        .pari    (pari),
        .ne      (ne),
        .zero    (zero),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result, carry flag and latency from plain integer arithmetic.
    function automatic void model(input int c, input int a, input int b,
                                  output int r, output int co, output int lat);
        int m;
        int n;
        m   = 1 << W;
        n   = a % W;
        co  = 0;
        lat = 1;
        case (c)
            0: begin r = (a + b) % m; co = ((a + b) >= m) ? 1 : 0; end
            1: begin r = ((b >> n) | (b << (W - n))) % m; lat = 1 + n; end
            2: r = (m - 1) - (a & b);
            3: r = b;
            4: begin r = (a - b + m) % m; co = (a >= b) ? 1 : 0; end
            5: begin r = (a * b) % m; lat = 1 + W; end
            6: begin r = ((b << n) | (b >> (W - n))) % m; lat = 1 + n; end
            default: r = a ^ b;
        endcase
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check1({tag, ".ready"}, ready, 1'b1);
        check1({tag, ".done"}, done, 1'b0);
        checkw({tag, ".rslt"}, rslt, '0);
        check1({tag, ".pari"}, pari, 1'b0);
        check1({tag, ".ne"}, ne, 1'b0);
        check1({tag, ".zero"}, zero, 1'b0);
        check1({tag, ".cout"}, cout, 1'b0);
    endtask

    // One handshake: accept, wait (bounded) for done, check latency and outputs.
    task automatic do_op(input string tag, input logic [2:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int er, ec, el, lat, lowcnt;
        model(int'(c), int'(a), int'(b), er, ec, el);
        @(negedge clk);
        check1({tag, ".ready_in"}, ready, 1'b1);
        alu_cmd = c;
        inA     = a;
        inB     = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        lat    = 1;
        lowcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (ready === 1'b0) lowcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check1({tag, ".done"}, done, 1'b1);
        checki({tag, ".latency"}, lat, el);
        checki({tag, ".busy"}, lowcnt, el - 1);
        checkw({tag, ".rslt"}, rslt, W'(er));
        check1({tag, ".cout"}, cout, ec != 0);
        check1({tag, ".pari"}, pari, ($countones(er) % 2) != 0);
        check1({tag, ".zero"}, zero, er == 0);
        check1({tag, ".ne"}, ne, a != b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   bc [5];
        logic [W-1:0] ba [5];
        logic [W-1:0] bb [5];
        int er, ec, el;

        reset   = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        alu_cmd = '0;
        inA     = '0;
        inB     = '0;
        #12;
        check_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        do_op("add", 3'b000, 8'hF0, 8'h20);
        do_op("rotr3", 3'b001, 8'd3, 8'h81);
        do_op("rotr8", 3'b001, 8'd8, 8'h81);
        do_op("mul13x11", 3'b101, 8'd13, 8'd11);
        do_op("mulff", 3'b101, 8'hFF, 8'hFF);
        do_op("nand", 3'b010, 8'hFF, 8'hFF);
        do_op("sub_borrow", 3'b100, 8'h05, 8'h07);
        do_op("sub_eq", 3'b100, 8'h42, 8'h42);
        do_op("rotl7", 3'b110, 8'd7, 8'h01);

        // start held high with alternating single-cycle ops: one done per cycle
        bc = '{3'b000, 3'b111, 3'b100, 3'b011, 3'b010};
        for (int i = 0; i < 5; i++) begin
            ba[i] = W'($urandom);
            bb[i] = W'($urandom);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            alu_cmd = bc[i];
            inA     = ba[i];
            inB     = bb[i];
            start   = 1'b1;
            @(posedge clk);
            #1;
            model(int'(bc[i]), int'(ba[i]), int'(bb[i]), er, ec, el);
            check1("b2b.done", done, 1'b1);
            check1("b2b.ready", ready, 1'b1);
            checkw("b2b.rslt", rslt, W'(er));
            check1("b2b.cout", cout, ec != 0);
        end
        @(negedge clk);
        start = 1'b0;

        // MUL aborted by flush; a start during RUN is ignored; rslt holds 0x30
        do_op("pre_flush", 3'b001, 8'd3, 8'h81);
        @(negedge clk);
        alu_cmd = 3'b101;
        inA     = 8'd13;
        inB     = 8'd11;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check1("mul_run.ready", ready, 1'b0);
        @(negedge clk);
        alu_cmd = 3'b000;
        inA     = 8'h01;
        inB     = 8'h01;
        start   = 1'b1;
        @(posedge clk);
        #1;
        check1("ignored.ready", ready, 1'b0);
        check1("ignored.done", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check1("flush.ready", ready, 1'b1);
        check1("flush.done", done, 1'b0);
        checkw("flush.rslt", rslt, 8'h30);
        @(posedge clk);
        #1;
        check1("flush.done2", done, 1'b0);
        checkw("flush.rslt2", rslt, 8'h30);
        check1("flush.ne", ne, 1'b1);

        // asynchronous reset in the middle of a ROTL
        do_op("pre_reset", 3'b000, 8'hF0, 8'h20);
        @(negedge clk);
        alu_cmd = 3'b110;
        inA     = 8'd5;
        inB     = 8'h0F;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check1("rotl_mid.ready", ready, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_cleared("async_reset");
        @(negedge clk);
        reset = 1'b0;
        do_op("post_reset", 3'b000, 8'h7F, 8'h01);

        // random operations against the model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   rc;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rc = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? ra : W'($urandom);
            do_op("rand", rc, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
